// File: rtl/psum_buffer.sv
// psum_buffer: seven per-PE-row psum FIFO lanes with valid/ack handshakes and mode-gated lane enables.
module psum_buffer #(
    parameter int LANES  = 7,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_conv,
    input  logic [1:0]                  mode_in,
    input  logic [LANES*(DATA_W+1)-1:0] psum_in,
    input  logic [LANES-1:0]            pe_psum_ack,
    output logic [LANES-1:0]            psum_buffer_ack,
    output logic [LANES*(DATA_W+1)-1:0] psum_out
);
    localparam int PW = DATA_W + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [1:0]       mode;
    logic [3:0]       n_en;
    logic [LANES-1:0] en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode <= 2'd0;
        else if (start_conv) mode <= mode_in;
    end

    always_comb begin
        n_en = mode == 2'd3 ? 4'd7 : mode == 2'd2 ? 4'd5 : mode == 2'd1 ? 4'd3 : 4'd0;
        for (int i = 0; i < LANES; i++) en[i] = i < int'(n_en);
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [DATA_W-1:0] mem [DEPTH];
        logic [AW-1:0]     rd, wr;
        logic [AW:0]       cnt;
        logic              out_v, push, pop;
        assign push = psum_buffer_ack[g];
        assign out_v = en[g] & (cnt != '0);
        // start_conv flushes, so a pop in that cycle is dropped as well
        assign pop = out_v & pe_psum_ack[g] & ~start_conv;
        assign psum_buffer_ack[g] = en[g] & psum_in[g*PW+DATA_W] & (cnt < FULL) & ~start_conv;
        assign psum_out[g*PW +: PW] = out_v ? {1'b1, mem[rd]} : '0;
        always_ff @(posedge clk) begin
            if (push) mem[wr] <= psum_in[g*PW +: DATA_W];
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst || start_conv) begin
                rd  <= '0;
                wr  <= '0;
                cnt <= '0;
            end else begin
                if (push) wr <= wr + 1'b1;
                if (pop) rd <= rd + 1'b1;
                cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end
endmodule

// File: tb/tb_psum_buffer.sv
// tb_psum_buffer: directed and random stimulus against a queue-based reference model of the lanes.
module tb_psum_buffer;
    logic          clk = 1'b0;
    logic          rst;
    logic          start_conv;
    logic [1:0]    mode_in;
    logic [118:0]  psum_in;
    logic [6:0]    pe_psum_ack;
    logic [6:0]    psum_buffer_ack;
    logic [118:0]  psum_out;

    psum_buffer dut (
        .clk(clk), .rst(rst), .start_conv(start_conv), .mode_in(mode_in),
        .psum_in(psum_in), .pe_psum_ack(pe_psum_ack),
        .psum_buffer_ack(psum_buffer_ack), .psum_out(psum_out)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [1:0] m_mode;
    logic [15:0] q [7][$];

    task automatic model_clear();
        for (int i = 0; i < 7; i++) q[i].delete();
    endtask

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic offer(input int lane, input logic [15:0] d);
        psum_in[lane*17 +: 17] = {1'b1, d};
    endtask

    // Called right after a negedge with inputs set; checks, then advances one clock.
    task automatic step(input string tag);
        logic [6:0]   ea;
        logic [118:0] eo;
        int           n;
        n = m_mode == 2'd3 ? 7 : m_mode == 2'd2 ? 5 : m_mode == 2'd1 ? 3 : 0;
        ea = '0;
        eo = '0;
        for (int i = 0; i < n; i++) begin
            ea[i] = psum_in[i*17+16] && q[i].size() < 4 && !start_conv && !rst;
            if (q[i].size() > 0 && !rst) eo[i*17 +: 17] = {1'b1, q[i][0]};
        end
        #1;
        vectors++;
        assert (psum_buffer_ack === ea) else begin
            miscompares++;
            $error("FAIL %s ack got %h exp %h", tag, psum_buffer_ack, ea);
        end
        vectors++;
        assert (psum_out === eo) else begin
            miscompares++;
            $error("FAIL %s out got %h exp %h", tag, psum_out, eo);
        end
        @(posedge clk);
        if (rst) begin
            m_mode = 2'd0;
            model_clear();
        end else if (start_conv) begin
            m_mode = mode_in;
            model_clear();
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (eo[i*17+16] && pe_psum_ack[i]) void'(q[i].pop_front());
                if (ea[i]) q[i].push_back(psum_in[i*17 +: 16]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start_conv = 1'b0; mode_in = 2'd0; psum_in = '0; pe_psum_ack = '0;
        m_mode = 2'd0;
        model_clear();
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            psum_in = {$urandom, $urandom, $urandom, $urandom};
            pe_psum_ack = 7'($urandom);
            mode_in = 2'($urandom);
            step("reset");
        end
        rst = 1'b0; pe_psum_ack = '0;
        for (int i = 0; i < 7; i++) offer(i, 16'(i + 1));
        step("off_mode");
        psum_in = '0; start_conv = 1'b1; mode_in = 2'd3;
        step("start3");
        start_conv = 1'b0;
        offer(3, 16'h1234);
        step("l3_push");
        chk("l3_out", psum_out[51 +: 17], 17'h11234);
        psum_in = '0; pe_psum_ack[3] = 1'b1;
        step("l3_pop");
        pe_psum_ack = '0;
        chk("l3_empty", psum_out[51 +: 17], 17'h0);
        for (int k = 1; k <= 5; k++) begin
            offer(0, 16'(k));
            step("l0_fill");
        end
        chk("l0_full_ack", {16'h0, psum_buffer_ack[0]}, 17'h0);
        psum_in = '0; pe_psum_ack[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            chk("l0_order", psum_out[0 +: 17], k <= 4 ? {1'b1, 16'(k)} : 17'h0);
            step("l0_pop");
        end
        pe_psum_ack = '0; start_conv = 1'b1; mode_in = 2'd1;
        step("start1");
        start_conv = 1'b0;
        for (int i = 0; i < 7; i++) offer(i, 16'h100 + 16'(i));
        step("mode1_offer");
        for (int i = 3; i < 7; i++) chk("mode1_off_lane", psum_out[i*17 +: 17], 17'h0);
        chk("mode1_lane2", psum_out[34 +: 17], 17'h10102);
        psum_in = '0;
        for (int k = 0; k < 3; k++) begin
            offer(2, 16'h200 + 16'(k));
            step("l2_fill");
        end
        offer(2, 16'h2AA); pe_psum_ack[2] = 1'b1;
        step("l2_full_pop");
        chk("l2_after_pop", psum_out[34 +: 17], 17'h10200);
        pe_psum_ack = '0;
        step("l2_accept");
        psum_in = '0;
        for (int k = 0; k < 4; k++) begin
            pe_psum_ack[2] = 1'b1;
            step("l2_drain");
        end
        chk("l2_last", psum_out[34 +: 17], 17'h0);
        pe_psum_ack = '0; start_conv = 1'b1; mode_in = 2'd3;
        step("start3b");
        start_conv = 1'b0;
        for (int k = 0; k < 2; k++) begin
            offer(0, 16'hA0 + 16'(k));
            step("flush_fill");
        end
        start_conv = 1'b1; offer(0, 16'hBEEF);
        step("flush_start");
        start_conv = 1'b0; psum_in = '0;
        chk("flush_out", psum_out[0 +: 17], 17'h0);
        for (int i = 0; i < 5; i++) offer(i, 16'hC00 + 16'(i));
        step("pre_areset");
        psum_in = '0;
        #2 rst = 1'b1;
        #1 chk("areset_l0", psum_out[0 +: 17], 17'h0);
        chk("areset_ack", {10'h0, psum_buffer_ack}, 17'h0);
        m_mode = 2'd0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        start_conv = 1'b1; mode_in = 2'd3;
        step("start_rand");
        for (int k = 0; k < 600; k++) begin
            start_conv = ($urandom_range(0, 39) == 0);
            mode_in = 2'($urandom);
            psum_in = {$urandom, $urandom, $urandom, $urandom};
            pe_psum_ack = 7'($urandom);
            step("random");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
